// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding select, load-use hazard stall FSM and stall-cycle counter
module hazard_forward_unit #(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NSRC*AW-1:0]   id_src_i,
  input  logic [NSRC-1:0]      id_src_used_i,
  input  logic [NSRC*AW-1:0]   ex_src_i,
  input  logic [AW-1:0]        ex_rd_i,
  input  logic                 ex_memread_i,
  input  logic [AW-1:0]        mem_rd_i,
  input  logic                 mem_regwrite_i,
  input  logic [AW-1:0]        wb_rd_i,
  input  logic                 wb_regwrite_i,
  input  logic                 pipe_hold_i,
  output logic [2*NSRC-1:0]    fwd_sel_o,
  output logic                 stall_if_o,
  output logic                 flush_ex_o,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);
  typedef enum logic {IDLE, STALL} state_e;
  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             haz, stall;
  // per-operand source select; EX/MEM beats MEM/WB and r0 is never forwarded
  always_comb begin
    fwd_sel_o = '0;
    for (int i = 0; i < NSRC; i++)
      fwd_sel_o[2*i +: 2] = (mem_regwrite_i && mem_rd_i != '0 && mem_rd_i == ex_src_i[i*AW +: AW]) ? 2'b10 :
                            (wb_regwrite_i && wb_rd_i != '0 && wb_rd_i == ex_src_i[i*AW +: AW]) ? 2'b01 : 2'b00;
  end
  // load in EX whose destination is read by the ID-stage instruction
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < NSRC; i++)
      haz = haz | (id_src_used_i[i] && id_src_i[i*AW +: AW] == ex_rd_i);
    haz = haz & ex_memread_i & (ex_rd_i != '0);
  end
  // stall FSM next state; an external hold freezes it and suppresses bubbles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (!pipe_hold_i) begin
      if (state_q == IDLE) begin
        stall   = haz;
        state_d = (haz && LOAD_LAT > 1) ? STALL : IDLE;
        cnt_d   = (haz && LOAD_LAT > 1) ? 3'(LOAD_LAT - 1) : cnt_q;
      end else begin
        stall   = 1'b1;
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd1) ? IDLE : STALL;
      end
    end
  end
  // saturating count of stalled cycles
  always_comb stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  // state, bubble counter and perf counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign stall_if_o  = stall & rst_ni;
  assign flush_ex_o  = stall & rst_ni;
  assign busy_o      = state_q != IDLE;
  assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: scoreboard bench over three parameterisations of hazard_forward_unit
module tb_hazard_forward_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [9:0]  id_src = '0, ex_src = '0;
  logic [1:0]  used = '0;
  logic [4:0]  ex_rd = '0, mem_rd = '0, wb_rd = '0;
  logic        mr1 = 1'b0, mr3 = 1'b0, mem_rw = 1'b0, wb_rw = 1'b0, hold = 1'b0;
  logic [14:0] id_src_n = '0, ex_src_n = '0;
  logic [2:0]  used_n = '0;
  logic [4:0]  ex_rd_n = '0, mem_rd_n = '0, wb_rd_n = '0;
  logic        mr_n = 1'b0, mem_rw_n = 1'b0, wb_rw_n = 1'b0;
  logic [3:0]  fwd1, fwd3;
  logic [5:0]  fwdn;
  logic        st1, fl1, bz1, st3, fl3, bz3, stn, fln, bzn;
  logic [15:0] cnt1;
  logic [3:0]  cnt3;
  logic [7:0]  cntn;
  hazard_forward_unit #(.AW(5), .NSRC(2), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .id_src_i(id_src), .id_src_used_i(used), .ex_src_i(ex_src),
    .ex_rd_i(ex_rd), .ex_memread_i(mr1), .mem_rd_i(mem_rd), .mem_regwrite_i(mem_rw),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_rw), .pipe_hold_i(hold), .fwd_sel_o(fwd1),
    .stall_if_o(st1), .flush_ex_o(fl1), .busy_o(bz1), .stall_cnt_o(cnt1));
  hazard_forward_unit #(.AW(5), .NSRC(2), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n), .id_src_i(id_src), .id_src_used_i(used), .ex_src_i(ex_src),
    .ex_rd_i(ex_rd), .ex_memread_i(mr3), .mem_rd_i(mem_rd), .mem_regwrite_i(mem_rw),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_rw), .pipe_hold_i(hold), .fwd_sel_o(fwd3),
    .stall_if_o(st3), .flush_ex_o(fl3), .busy_o(bz3), .stall_cnt_o(cnt3));
  hazard_forward_unit #(.AW(5), .NSRC(3), .LOAD_LAT(2), .CNT_W(8)) u_n3 (
    .clk_i(clk), .rst_ni(rst_n), .id_src_i(id_src_n), .id_src_used_i(used_n), .ex_src_i(ex_src_n),
    .ex_rd_i(ex_rd_n), .ex_memread_i(mr_n), .mem_rd_i(mem_rd_n), .mem_regwrite_i(mem_rw_n),
    .wb_rd_i(wb_rd_n), .wb_regwrite_i(wb_rw_n), .pipe_hold_i(1'b0), .fwd_sel_o(fwdn),
    .stall_if_o(stn), .flush_ex_o(fln), .busy_o(bzn), .stall_cnt_o(cntn));
  typedef struct {
    int          dut;
    logic        chk_fwd;
    logic [7:0]  fwd;
    logic        stall;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_err = 0;
  // compare one observed value with its expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push(input int dut, input logic chk_fwd, input logic [7:0] fwd,
                      input logic stall, input logic busy, input logic [15:0] cnt);
    q.push_back('{dut, chk_fwd, fwd, stall, busy, cnt});
  endtask
  // compare all queued expectations mid-cycle, then advance to just after the next edge
  task automatic tick();
    exp_t e;
    logic [7:0] of;
    logic os, ofl, ob;
    logic [15:0] oc;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      of  = (e.dut == 0) ? {4'b0, fwd1} : (e.dut == 1) ? {4'b0, fwd3} : {2'b0, fwdn};
      os  = (e.dut == 0) ? st1 : (e.dut == 1) ? st3 : stn;
      ofl = (e.dut == 0) ? fl1 : (e.dut == 1) ? fl3 : fln;
      ob  = (e.dut == 0) ? bz1 : (e.dut == 1) ? bz3 : bzn;
      oc  = (e.dut == 0) ? cnt1 : (e.dut == 1) ? {12'b0, cnt3} : {8'b0, cntn};
      if (e.chk_fwd) check($sformatf("d%0d fwd_sel", e.dut), 32'(of), 32'(e.fwd));
      check($sformatf("d%0d stall_if", e.dut), 32'(os), 32'(e.stall));
      check($sformatf("d%0d flush_ex", e.dut), 32'(ofl), 32'(e.stall));
      check($sformatf("d%0d busy", e.dut), 32'(ob), 32'(e.busy));
      check($sformatf("d%0d stall_cnt", e.dut), 32'(oc), 32'(e.cnt));
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [1:0] fsel(input logic [4:0] src, input logic [4:0] mrd, input logic mrw,
                                      input logic [4:0] wrd, input logic wrw);
    if (mrw && mrd != 5'd0 && mrd == src) return 2'b10;
    if (wrw && wrd != 5'd0 && wrd == src) return 2'b01;
    return 2'b00;
  endfunction
  initial begin
    logic [7:0] fm;
    logic [4:0] a;
    logic hz;
    int rem, cm;
    for (int d = 0; d < 3; d++) push(d, 1, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    mem_rd = 5; wb_rd = 5; mem_rw = 1; wb_rw = 1; ex_src = {5'd0, 5'd5};
    push(0, 1, 8'h2, 0, 0, 0); push(1, 1, 8'h2, 0, 0, 0); tick();
    mem_rd = 0; wb_rd = 0; ex_src = '0;
    push(0, 1, 8'h0, 0, 0, 0); push(1, 1, 8'h0, 0, 0, 0); tick();
    mem_rd = 5; wb_rd = 5; mem_rw = 0; ex_src = {5'd0, 5'd5};
    push(0, 1, 8'h1, 0, 0, 0); push(1, 1, 8'h1, 0, 0, 0); tick();
    mem_rd = 7; wb_rd = 7; mem_rw = 1; ex_src = {5'd7, 5'd3};
    push(0, 1, 8'h8, 0, 0, 0); tick();
    mem_rd = 9; wb_rd = 3; ex_src = {5'd9, 5'd3};
    push(0, 1, 8'h9, 0, 0, 0); tick();
    mem_rd = 0; wb_rd = 0; mem_rw = 0; wb_rw = 0; ex_src = '0;
    mr1 = 1; ex_rd = 8; id_src = {5'd8, 5'd0}; used = 2'b10;
    push(0, 1, 0, 1, 0, 0); push(1, 0, 0, 0, 0, 0); tick();
    mr1 = 0;
    push(0, 0, 0, 0, 0, 1); tick();
    mr1 = 1; used = 2'b01;
    push(0, 0, 0, 0, 0, 1); tick();
    ex_rd = 0; id_src = '0; used = 2'b11;
    push(0, 0, 0, 0, 0, 1); tick();
    ex_rd = 8; id_src = {5'd8, 5'd0}; used = 2'b10; hold = 1;
    push(0, 0, 0, 0, 0, 1); tick();
    push(0, 0, 0, 0, 0, 1); tick();
    hold = 0;
    push(0, 0, 0, 1, 0, 1); tick();
    mr1 = 0;
    push(0, 0, 0, 0, 0, 2); tick();
    mr3 = 1;
    push(1, 0, 0, 1, 0, 0); tick();
    push(1, 0, 0, 1, 1, 1); tick();
    push(1, 0, 0, 1, 1, 2); tick();
    mr3 = 0;
    push(1, 0, 0, 0, 0, 3); push(0, 0, 0, 0, 0, 2); tick();
    mr3 = 1;
    push(1, 0, 0, 1, 0, 3); tick();
    mr3 = 0; hold = 1;
    for (int i = 0; i < 4; i++) begin
      push(1, 0, 0, 0, 1, 4); tick();
    end
    hold = 0;
    push(1, 0, 0, 1, 1, 4); tick();
    push(1, 0, 0, 1, 1, 5); tick();
    push(1, 0, 0, 0, 0, 6); tick();
    mr3 = 1;
    push(1, 0, 0, 1, 0, 6); tick();
    mr3 = 0;
    push(1, 0, 0, 1, 1, 7); tick();
    rst_n = 0;
    for (int d = 0; d < 3; d++) push(d, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1; mr3 = 1;
    for (int i = 0; i <= 20; i++) begin
      push(1, 0, 0, 1, (i % 3) != 0, (i > 15) ? 16'd15 : 16'(i)); tick();
    end
    mr3 = 0;
    push(1, 0, 0, 0, 0, 15); tick();
    rem = 0; cm = 0;
    for (int k = 0; k < 150; k++) begin
      for (int j = 0; j < 3; j++) begin
        a = 5'($urandom_range(0, 3)); id_src_n[j*5 +: 5] = a;
        a = 5'($urandom_range(0, 3)); ex_src_n[j*5 +: 5] = a;
      end
      used_n = 3'($urandom_range(0, 7));
      ex_rd_n = 5'($urandom_range(0, 3)); mem_rd_n = 5'($urandom_range(0, 3)); wb_rd_n = 5'($urandom_range(0, 3));
      mr_n = 1'($urandom_range(0, 1)); mem_rw_n = 1'($urandom_range(0, 1)); wb_rw_n = 1'($urandom_range(0, 1));
      fm = '0; hz = 1'b0;
      for (int j = 0; j < 3; j++) begin
        fm[2*j +: 2] = fsel(ex_src_n[j*5 +: 5], mem_rd_n, mem_rw_n, wb_rd_n, wb_rw_n);
        if (used_n[j] && id_src_n[j*5 +: 5] == ex_rd_n) hz = 1'b1;
      end
      hz = hz && mr_n && ex_rd_n != 5'd0;
      push(2, 1, fm, rem > 0 || hz, rem > 0, 16'(cm));
      if (rem > 0 || hz) cm++;
      if (rem > 0) rem--;
      else if (hz) rem = 1;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and load-use hazard controller for the 5-stage pipeline. Selects EX-stage operand sources for NSRC source operands from the EX/MEM and MEM/WB results. Detects load-use hazards between the EX-stage load and the ID-stage instruction, and runs a small stall FSM that inserts LOAD_LAT bubbles. Also keeps a saturating stall-cycle counter for performance monitoring.

## Interface

- AW, 5, register-address width
- NSRC, 2, source operands per instruction (1..4); operand i occupies bits [i*AW +: AW]
- LOAD_LAT, 1, bubbles inserted per load-use hazard (1..7)
- CNT_W, 16, width of stall counter

- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_src  in  NSRC*AW  source register addresses of ID-stage instruction
- id_src_used  in  NSRC  per-operand "this source is actually read" flags
- ex_src  in  NSRC*AW  source register addresses of EX-stage instruction
- ex_rd  in  AW  destination of EX-stage instruction
- ex_memread  in  1  EX-stage instruction is a load
- mem_rd, mem_regwrite  in  AW, 1  EX/MEM destination / write enable
- wb_rd, wb_regwrite  in  AW, 1  MEM/WB destination / write enable
- pipe_hold  in  1  external global freeze (e.g. cache miss)
- fwd_sel  out  2*NSRC  per-operand select, [2i+1:2i]: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall_if  out  1  hold PC and IF/ID register
- flush_ex  out  1  load bubble into ID/EX register
- busy  out  1  FSM not in IDLE
- stall_cnt  out  CNT_W  cycles with stall_if high, saturating

## Operation

**Forwarding (combinational, per operand i)**
- If mem_regwrite, mem_rd != 0 and mem_rd == ex_src[i], the select is 10.
- Otherwise, if wb_regwrite, wb_rd != 0 and wb_rd == ex_src[i], the select is 01.
- Otherwise the select is 00.
- EX/MEM always wins over MEM/WB.
- Register 0 is never forwarded.

**Hazard detect (combinational)**
- haz = ex_memread AND ex_rd != 0 AND, for some i, (id_src_used[i] AND id_src[i] == ex_rd).

**FSM states: IDLE, STALL**
- IDLE:
  - When haz is high and pipe_hold is low: assert stall_if and flush_ex in the same cycle.
  - If LOAD_LAT > 1, load cnt = LOAD_LAT-1 and go to STALL; otherwise stay in IDLE.
- STALL:
  - stall_if = 1 and flush_ex = 1 every cycle.
  - If pipe_hold is low, decrement cnt; when cnt reaches 1 and decrements to 0, return to IDLE.
  - haz is ignored in STALL, because the load has already left EX.
- pipe_hold high:
  - The FSM and cnt freeze.
  - stall_if and flush_ex are forced low; the external hold already freezes all stages, and a bubble must not be injected.
  - In IDLE, a haz is not acted upon while pipe_hold is high. It is taken in the first cycle pipe_hold is low.

**stall_cnt**
- Increments on every clock edge where stall_if = 1.
- Saturates at 2^CNT_W-1; it does not wrap.

**Reset**
- Asynchronous reset returns the FSM to IDLE, cnt = 0, stall_cnt = 0.
- Reset mid-STALL abandons the stall immediately.

## Timing

- fwd_sel, stall_if and flush_ex are combinational from inputs and state, valid in the same cycle.
- busy is registered (state != IDLE).
- Reset values:
  - fwd_sel depends only on inputs; with all-zero inputs it is all 00.
  - stall_if = 0, flush_ex = 0, busy = 0, stall_cnt = 0.
- Total bubbles per hazard = LOAD_LAT exactly, counting only cycles with pipe_hold low.
- With LOAD_LAT = 1, busy never rises.
- The consumer reaches EX when the load is in MEM/WB (LOAD_LAT = 1) or already written. The register file is write-before-read.

## Test plan

- **Priority and r0:** mem_rd = wb_rd = 5, both regwrite, ex_src[0] = 5 -> fwd_sel[1:0] = 10. Then mem_rd = 0, wb_rd = 0, ex_src = 0 -> 00. Then mem_regwrite = 0 -> 01.
- **Load-use, LOAD_LAT = 1:** ex_memread = 1, ex_rd = 8, id_src[1] = 8, id_src_used[1] = 1 -> stall_if = flush_ex = 1 for exactly one cycle; busy stays 0; stall_cnt = 1. With id_src_used[1] = 0 -> no stall.
- **LOAD_LAT = 3:** same hazard -> stall_if high for 3 consecutive cycles, busy high for cycles 2-3, stall_cnt = 3. A second haz presented during STALL is ignored.
- **pipe_hold mid-stall:** LOAD_LAT = 3, assert pipe_hold in the second stall cycle for 4 cycles -> stall_if low during the hold, FSM frozen. Exactly 3 stall cycles in total; busy remains high across the hold.
- **Reset mid-STALL and saturation:**
  - rst_n low in STALL -> busy, stall_if and stall_cnt go to 0 immediately.
  - With CNT_W = 4, 20 back-to-back stall cycles -> stall_cnt = 15.
- **NSRC = 3 sweep:** randomised addresses against a reference model, checking every operand's fwd_sel and haz each cycle.
